// File: rtl/mux_in_pico.sv
// PicoBlaze IN_PORT multiplexer: one registered byte chosen by port_id from RTC and keypad sources.
// Optional build macro MUX_INPICO_DEVID_EN adds a device-ID byte (0x0A) and an id_port loopback (0x0B).
module mux_in_pico #(
   parameter int                 DATA_W      = 8,
   parameter logic [DATA_W-1:0]  DEFAULT_VAL = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] seg_rtc,
   input  logic [DATA_W-1:0] min_rtc,
   input  logic [DATA_W-1:0] hora_rtc,
   input  logic [DATA_W-1:0] dia_rtc,
   input  logic [DATA_W-1:0] mes_rtc,
   input  logic [DATA_W-1:0] year_rtc,
   input  logic [DATA_W-1:0] seg_tim_rtc,
   input  logic [DATA_W-1:0] min_tim_rtc,
   input  logic [DATA_W-1:0] hora_tim_rtc,
   input  logic [DATA_W-1:0] tecla,
   input  logic [7:0]        id_port,
   output logic [DATA_W-1:0] dato_inpico
);

   logic [DATA_W-1:0] sel_s;
   logic [DATA_W-1:0] dato_r;

`ifdef MUX_INPICO_DEVID_EN
   logic [7:0] id_last_r;

   // Loopback of the id_port value seen at the previous edge, for firmware self-test.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_last_r <= 8'h00;
      end else begin
         id_last_r <= id_port;
      end
   end
`endif

   // Source selection; anything unmapped (including undefined encodings) falls to DEFAULT_VAL.
   always_comb begin
      sel_s = DEFAULT_VAL;
      case (id_port)
         8'h00:   sel_s = seg_rtc;
         8'h01:   sel_s = min_rtc;
         8'h02:   sel_s = hora_rtc;
         8'h03:   sel_s = dia_rtc;
         8'h04:   sel_s = mes_rtc;
         8'h05:   sel_s = year_rtc;
         8'h06:   sel_s = seg_tim_rtc;
         8'h07:   sel_s = min_tim_rtc;
         8'h08:   sel_s = hora_tim_rtc;
         8'h09:   sel_s = tecla;
`ifdef MUX_INPICO_DEVID_EN
         8'h0A:   sel_s = DATA_W'(8'hA5);
         8'h0B:   sel_s = DATA_W'(id_last_r);
`endif
         default: sel_s = DEFAULT_VAL;
      endcase
   end

   // Single output register giving the one-cycle latency PicoBlaze INPUT expects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dato_r <= {DATA_W{1'b0}};
      end else begin
         dato_r <= sel_s;
      end
   end

   assign dato_inpico = dato_r;

endmodule

// File: tb/tb_mux_in_pico.sv
// Self-checking bench for mux_in_pico: reset, full selection map, latency and mid-cycle reset.
`timescale 1ns/1ps
module tb_mux_in_pico;

   logic       clk;
   logic       reset;
   logic [7:0] seg_rtc, min_rtc, hora_rtc, dia_rtc, mes_rtc;
   logic [7:0] year_rtc, seg_tim_rtc, min_tim_rtc, hora_tim_rtc, tecla;
   logic [7:0] id_port;
   logic [7:0] dato_inpico;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] id;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[16];

   mux_in_pico dut (
      .clk          (clk),
      .reset        (reset),
      .seg_rtc      (seg_rtc),
      .min_rtc      (min_rtc),
      .hora_rtc     (hora_rtc),
      .dia_rtc      (dia_rtc),
      .mes_rtc      (mes_rtc),
      .year_rtc     (year_rtc),
      .seg_tim_rtc  (seg_tim_rtc),
      .min_tim_rtc  (min_tim_rtc),
      .hora_tim_rtc (hora_tim_rtc),
      .tecla        (tecla),
      .id_port      (id_port),
      .dato_inpico  (dato_inpico)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] exp);
      n_chk++;
      if (dato_inpico !== exp) begin
         n_fail++;
         $display("FAIL %s: dato_inpico=%h expected=%h at %0t", name, dato_inpico, exp, $time);
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 10; i++) begin
         vecs[i].id  = 8'(i);
         vecs[i].exp = 8'(i + 1);
      end
      vecs[10] = '{8'h01, 8'h02};
      vecs[11] = '{8'h02, 8'h03};
      vecs[12] = '{8'h0C, 8'h00};
      vecs[13] = '{8'hFF, 8'h00};
`ifdef MUX_INPICO_DEVID_EN
      vecs[14] = '{8'h0A, 8'hA5};
      vecs[15] = '{8'h0B, 8'h0A};
`else
      vecs[14] = '{8'h0A, 8'h00};
      vecs[15] = '{8'h0B, 8'h00};
`endif

      reset        = 1'b1;
      seg_rtc      = 8'd1;
      min_rtc      = 8'd2;
      hora_rtc     = 8'd3;
      dia_rtc      = 8'd4;
      mes_rtc      = 8'd5;
      year_rtc     = 8'd6;
      seg_tim_rtc  = 8'd7;
      min_tim_rtc  = 8'd8;
      hora_tim_rtc = 8'd9;
      tecla        = 8'd10;
      id_port      = 8'h00;

      repeat (3) @(posedge clk);
      #1 chk("reset_hold", 8'h00);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("reset_release_pre_edge", 8'h00);
      @(posedge clk);
      #1 chk("reset_first_edge", 8'h01);

      // Table: each id held 100 ns; value must be old before the edge and new after it.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         id_port = vecs[i].id;
         #1 chk($sformatf("pre_edge_id%02h", vecs[i].id), (i == 0) ? 8'h01 : vecs[i-1].exp);
         @(posedge clk);
         #1 chk($sformatf("sel_id%02h", vecs[i].id), vecs[i].exp);
         repeat (4) @(posedge clk);
      end

      // id_port changing every cycle: no hold or hysteresis.
      for (int i = 9; i >= 0; i--) begin
         @(negedge clk);
         id_port = 8'(i);
         @(posedge clk);
         #1 chk($sformatf("fast_id%0d", i), 8'(i + 1));
      end

      // Source change while id_port held.
      @(negedge clk);
      id_port = 8'h03;
      @(posedge clk);
      #1 chk("dia_before_change", 8'h04);
      @(negedge clk);
      dia_rtc = 8'h31;
      #1 chk("dia_changed_pre_edge", 8'h04);
      @(posedge clk);
      #1 chk("dia_changed_post_edge", 8'h31);

      // Reset asserted between edges clears at once and blocks clocked loads.
      #4 reset = 1'b1;
      #1 chk("midcycle_reset_immediate", 8'h00);
      @(posedge clk);
      #1 chk("reset_suppresses_load", 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 chk("after_midcycle_reset", 8'h31);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
